// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave. The sclk, ss and mosi pins are synchronised into
// clk. Received words are offered on a level-valid/ack port. Transmit words are
// staged in a one-entry holding register that uses a valid/ready handshake.
module spi_slave #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic             r_ss_s1, r_ss_s2, r_ss_d;
  logic             r_mosi_s1, r_mosi_s2;

  logic [WIDTH-1:0] r_tx_shift;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  // Only WIDTH-1 bits are kept: the last bit of a word goes straight into rx_data.
  logic [WIDTH-2:0] r_rx_shift;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_word_done;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic             r_overrun;

  logic             w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
  logic             w_active, w_start, w_rise, w_fall, w_end, w_word;
  logic             w_consume, w_load;
  logic [WIDTH-1:0] w_rx_next;

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
  assign w_ss_fall   = ~r_ss_s2 & r_ss_d;
  assign w_ss_rise   = r_ss_s2 & ~r_ss_d;

  assign w_active  = (r_state == ACTIVE);
  assign w_start   = (r_state == IDLE) && w_ss_fall;
  assign w_rise    = w_active && w_sclk_rise;
  assign w_fall    = w_active && w_sclk_fall;
  assign w_end     = w_active && w_ss_rise;
  assign w_word    = w_rise && (r_bit_cnt == CW'(WIDTH - 1));
  assign w_consume = w_start || (w_fall && r_word_done);
  assign w_load    = tx_valid && !r_hold_full;
  assign w_rx_next = {r_rx_shift, r_mosi_s2};

  // Two-flop synchronisers, plus history flops for edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sclk_s1 <= 1'b0; r_sclk_s2 <= 1'b0; r_sclk_d <= 1'b0;
      r_ss_s1   <= 1'b1; r_ss_s2   <= 1'b1; r_ss_d   <= 1'b1;
      r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= sclk; r_sclk_s2 <= r_sclk_s1; r_sclk_d <= r_sclk_s2;
      r_ss_s1   <= ss;   r_ss_s2   <= r_ss_s1;   r_ss_d   <= r_ss_s2;
      r_mosi_s1 <= mosi; r_mosi_s2 <= r_mosi_s1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state: frame framing is driven by synchronised ss only
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_ss_fall) w_state_nxt = ACTIVE;
      ACTIVE:  if (w_ss_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs and register-backed status outputs
  always_comb begin
    busy     = w_active;
    miso_oe  = w_active;
    miso     = w_active ? r_tx_shift[WIDTH-1] : 1'b0;
    tx_ready = !r_hold_full;
    rx_data  = r_rx_data;
    rx_valid = r_rx_valid;
    overrun  = r_overrun;
  end

  // Transmit path: the shift register draws from the holding register. A load
  // into an empty holding register in the same cycle as a consume wins over the consume.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_shift  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      if (w_consume)   r_tx_shift <= r_hold_full ? r_hold : '0;
      else if (w_fall) r_tx_shift <= r_tx_shift << 1;

      if (w_load) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end else if (w_consume) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  // Receive shifting and bit counting; a frame end also discards any partial word
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_shift  <= '0;
      r_bit_cnt   <= '0;
      r_word_done <= 1'b0;
    end else begin
      if (w_start) begin
        r_bit_cnt   <= '0;
        r_word_done <= 1'b0;
      end
      if (w_rise) begin
        r_rx_shift <= w_rx_next[WIDTH-2:0];
        if (w_word) begin
          r_bit_cnt   <= '0;
          r_word_done <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + CW'(1);
        end
      end
      if (w_fall && r_word_done) r_word_done <= 1'b0;
      if (w_end) begin
        r_bit_cnt   <= '0;
        r_word_done <= 1'b0;
      end
    end
  end

  // Receive handshake: a completing word takes priority over an ack
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (w_word) begin
      r_rx_data  <= w_rx_next;
      r_rx_valid <= 1'b1;
      if (r_rx_valid && !rx_ack) r_overrun <= 1'b1;
    end else if (rx_ack) begin
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master stimulus with scoreboard queues. Received
// words and master-captured miso words are checked by separate monitor processes.
module tb_spi_slave;

  localparam int H = 8;  // SCLK half period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sclk = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_mi_q[$];
  logic [7:0] got_mi_q[$];
  logic [7:0] g;

  spi_slave #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ack(rx_ack), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_miso"},     miso, 0);
    chk({tag, "_miso_oe"},  miso_oe, 0);
    chk({tag, "_busy"},     busy, 0);
    chk({tag, "_tx_ready"}, tx_ready, 1);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_rx_data"},  rx_data, 0);
    chk({tag, "_overrun"},  overrun, 0);
  endtask

  task automatic load_tx(input logic [7:0] v);
    int n = 0;
    while (!tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tx_ready_wait", tx_ready, 1);
    tx_data  = v;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic ss_begin();
    @(negedge clk);
    ss = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic ss_end();
    repeat (H) @(negedge clk);
    ss = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  // Mode 0: drive mosi while sclk is low, sample miso at the rising edge
  task automatic spi_word(input logic [7:0] mw, input int nbits, input bit do_ack,
                          output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mw[7-i];
      repeat (H) @(negedge clk);
      sclk = 1'b1;
      got  = {got[6:0], miso};
      repeat (H) @(negedge clk);
      sclk = 1'b0;
    end
    if (do_ack) begin
      repeat (2) @(negedge clk);
      pulse_ack();
    end
  endtask

  // Monitor: each newly presented received word is compared against the queue
  initial begin
    logic       pv = 1'b0;
    logic [7:0] pd = '0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset && rx_valid && (!pv || rx_data != pd)) begin
        if (exp_rx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_unexpected: got %0h, required no word", rx_data);
        end else begin
          e = exp_rx_q.pop_front();
          chk("rx_word", rx_data, e);
        end
      end
      pv = rx_valid;
      pd = rx_data;
    end
  end

  // Monitor: each word captured by the master from miso is compared against the queue
  initial begin
    logic [7:0] a, e;
    forever begin
      @(negedge clk);
      while (got_mi_q.size() != 0) begin
        a = got_mi_q.pop_front();
        if (exp_mi_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL miso_unexpected: got %0h, required no word", a);
        end else begin
          e = exp_mi_q.pop_front();
          chk("miso_word", a, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    chk_reset_vals("in_reset");
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk_reset_vals("post_reset");

    // Single word: slave sends A5, master sends 3C
    load_tx(8'hA5);
    chk("t1_tx_ready_full", tx_ready, 0);
    exp_rx_q.push_back(8'h3C);
    exp_mi_q.push_back(8'hA5);
    ss_begin();
    chk("t1_tx_ready_at_start", tx_ready, 1);
    chk("t1_busy", busy, 1);
    chk("t1_miso_oe", miso_oe, 1);
    spi_word(8'h3C, 8, 1'b0, g);
    got_mi_q.push_back(g);
    ss_end();
    chk("t1_rx_valid", rx_valid, 1);
    chk("t1_busy_end", busy, 0);
    pulse_ack();
    chk("t1_rx_valid_acked", rx_valid, 0);

    // Empty TX: master receives zeros
    exp_rx_q.push_back(8'hFF);
    exp_mi_q.push_back(8'h00);
    ss_begin();
    spi_word(8'hFF, 8, 1'b1, g);
    got_mi_q.push_back(g);
    ss_end();

    // Two-word frame, second TX word loaded while the first is shifting
    load_tx(8'h12);
    exp_rx_q.push_back(8'h55);
    exp_rx_q.push_back(8'hAA);
    exp_mi_q.push_back(8'h12);
    exp_mi_q.push_back(8'h34);
    fork
      begin
        ss_begin();
        spi_word(8'h55, 8, 1'b1, g);
        got_mi_q.push_back(g);
        spi_word(8'hAA, 8, 1'b1, g);
        got_mi_q.push_back(g);
        ss_end();
      end
      begin
        repeat (40) @(negedge clk);
        load_tx(8'h34);
      end
    join
    chk("t3_overrun", overrun, 0);
    chk("t3_rx_valid", rx_valid, 0);

    // Overrun: two words without ack
    exp_rx_q.push_back(8'h69);
    exp_rx_q.push_back(8'h96);
    exp_mi_q.push_back(8'h00);
    exp_mi_q.push_back(8'h00);
    ss_begin();
    spi_word(8'h69, 8, 1'b0, g);
    got_mi_q.push_back(g);
    spi_word(8'h96, 8, 1'b0, g);
    got_mi_q.push_back(g);
    ss_end();
    chk("t4_overrun", overrun, 1);
    chk("t4_rx_valid", rx_valid, 1);
    chk("t4_rx_data", rx_data, 8'h96);
    pulse_ack();
    chk("t4_overrun_cleared", overrun, 0);
    chk("t4_rx_valid_cleared", rx_valid, 0);

    // Abort after 5 bits; holding register loaded mid-frame must survive
    ss_begin();
    load_tx(8'hC3);
    spi_word(8'hF0, 5, 1'b0, g);
    ss_end();
    chk("t5_abort_rx_valid", rx_valid, 0);
    chk("t5_abort_busy", busy, 0);
    chk("t5_hold_kept", tx_ready, 0);
    exp_rx_q.push_back(8'h81);
    exp_mi_q.push_back(8'hC3);
    ss_begin();
    spi_word(8'h81, 8, 1'b0, g);
    got_mi_q.push_back(g);
    ss_end();
    chk("t5_rx_data", rx_data, 8'h81);
    pulse_ack();

    // Reset mid-frame
    load_tx(8'h77);
    ss_begin();
    spi_word(8'hE7, 3, 1'b0, g);
    chk("t6_busy_before", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("mid_reset");
    ss   = 1'b1;
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6_idle_after", busy, 0);
    chk("t6_miso_after", miso, 0);

    // Drain: anything still expected never appeared
    repeat (20) @(negedge clk);
    while (exp_rx_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL rx_missing: got none, required %0h", exp_rx_q.pop_front());
    end
    while (exp_mi_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL miso_missing: got none, required %0h", exp_mi_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
